indication_pipe_arb: RTL and testbench

- Sequences the shared 128-bit indication output pipe between two sources:
  - the method-to-pipe indication stream (in);
  - the printf message stream (forward).
- Replaces pure combinational muxing with per-source FIFO buffering and weighted round-robin arbitration.
- Guarantees neither source starves and no message is lost or reordered.
- Sits in the top level between the indication M2P converter, the DUT printf port, and the external indication pipe.

---
 rtl/indication_pipe_arb.sv | 122 ++++++++++++
 tb/tb_indication_pipe_arb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/indication_pipe_arb.sv
// Arbitrates the shared indication output pipe between the M2P indication stream and the
// printf forward stream, using a FIFO per source and weighted round-robin selection.
module indication_pipe_arb #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned FWD_WEIGHT = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_enq_ena_i,
  input  logic [DATA_WIDTH-1:0] in_enq_v_i,
  output logic                  in_enq_rdy_o,
  input  logic                  forward_enq_ena_i,
  input  logic [DATA_WIDTH-1:0] forward_enq_v_i,
  output logic                  forward_enq_rdy_o,
  output logic                  out_enq_ena_o,
  output logic [DATA_WIDTH-1:0] out_enq_v_o,
  input  logic                  out_enq_rdy_i,
  output logic [15:0]           stat_in_count_o,
  output logic [15:0]           stat_fwd_count_o
);

  localparam int unsigned PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned BurstW = $clog2(FWD_WEIGHT + 1);

  typedef enum logic {SrcIn, SrcFwd} src_e;

  logic [DATA_WIDTH-1:0] in_mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0] fwd_mem_q [DEPTH];
  logic [PtrW-1:0]       in_wptr_q, in_rptr_q, fwd_wptr_q, fwd_rptr_q;
  logic [PtrW-1:0]       in_wptr_d, in_rptr_d, fwd_wptr_d, fwd_rptr_d;
  logic [CntW-1:0]       in_cnt_q, in_cnt_d, fwd_cnt_q, fwd_cnt_d;
  src_e                  last_q, last_d;
  logic [BurstW-1:0]     burst_q, burst_d;
  logic [15:0]           in_stat_q, in_stat_d, fwd_stat_q, fwd_stat_d;

  logic in_ne, fwd_ne, in_push, fwd_push, in_pop, fwd_pop, sel_fwd, xfer;

  // RDY comes from registered counts only, so no enqueue input can reach an output.
  always_comb begin
    in_ne             = (in_cnt_q != '0);
    fwd_ne            = (fwd_cnt_q != '0);
    in_enq_rdy_o      = ~rst_i & (in_cnt_q != CntW'(DEPTH));
    forward_enq_rdy_o = ~rst_i & (fwd_cnt_q != CntW'(DEPTH));
    in_push           = in_enq_ena_i & in_enq_rdy_o;
    fwd_push          = forward_enq_ena_i & forward_enq_rdy_o;

    sel_fwd = fwd_ne & (~in_ne | (last_q == SrcIn) | (burst_q < BurstW'(FWD_WEIGHT)));
    xfer    = ~rst_i & out_enq_rdy_i & (in_ne | fwd_ne);
    fwd_pop = xfer & sel_fwd;
    in_pop  = xfer & ~sel_fwd;

    out_enq_ena_o    = xfer;
    out_enq_v_o      = sel_fwd ? fwd_mem_q[fwd_rptr_q] : in_mem_q[in_rptr_q];
    stat_in_count_o  = in_stat_q;
    stat_fwd_count_o = fwd_stat_q;
  end

  always_comb begin
    in_wptr_d  = in_push  ? in_wptr_q + PtrW'(1)  : in_wptr_q;
    in_rptr_d  = in_pop   ? in_rptr_q + PtrW'(1)  : in_rptr_q;
    fwd_wptr_d = fwd_push ? fwd_wptr_q + PtrW'(1) : fwd_wptr_q;
    fwd_rptr_d = fwd_pop  ? fwd_rptr_q + PtrW'(1) : fwd_rptr_q;

    in_cnt_d = in_cnt_q;
    if (in_push && !in_pop)      in_cnt_d = in_cnt_q + CntW'(1);
    else if (!in_push && in_pop) in_cnt_d = in_cnt_q - CntW'(1);

    fwd_cnt_d = fwd_cnt_q;
    if (fwd_push && !fwd_pop)      fwd_cnt_d = fwd_cnt_q + CntW'(1);
    else if (!fwd_push && fwd_pop) fwd_cnt_d = fwd_cnt_q - CntW'(1);

    last_d     = last_q;
    burst_d    = burst_q;
    in_stat_d  = in_stat_q;
    fwd_stat_d = fwd_stat_q;
    if (fwd_pop) begin
      last_d     = SrcFwd;
      fwd_stat_d = fwd_stat_q + 16'd1;
      if (last_q != SrcFwd)                   burst_d = BurstW'(1);
      else if (burst_q < BurstW'(FWD_WEIGHT)) burst_d = burst_q + BurstW'(1);
    end else if (in_pop) begin
      last_d    = SrcIn;
      burst_d   = '0;
      in_stat_d = in_stat_q + 16'd1;
    end
  end

  // Storage needs no reset; the counts alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (in_push)  in_mem_q[in_wptr_q]   <= in_enq_v_i;
    if (fwd_push) fwd_mem_q[fwd_wptr_q] <= forward_enq_v_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_wptr_q  <= '0;
      in_rptr_q  <= '0;
      fwd_wptr_q <= '0;
      fwd_rptr_q <= '0;
      in_cnt_q   <= '0;
      fwd_cnt_q  <= '0;
      last_q     <= SrcIn;
      burst_q    <= '0;
      in_stat_q  <= '0;
      fwd_stat_q <= '0;
    end else begin
      in_wptr_q  <= in_wptr_d;
      in_rptr_q  <= in_rptr_d;
      fwd_wptr_q <= fwd_wptr_d;
      fwd_rptr_q <= fwd_rptr_d;
      in_cnt_q   <= in_cnt_d;
      fwd_cnt_q  <= fwd_cnt_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      in_stat_q  <= in_stat_d;
      fwd_stat_q <= fwd_stat_d;
    end
  end

endmodule

// File: tb/tb_indication_pipe_arb.sv
// Scoreboard bench for indication_pipe_arb: directed stimulus pushes expected output words,
// a negedge monitor pops and compares every transfer.
module tb_indication_pipe_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_ena, fwd_ena, out_rdy;
  logic [127:0] in_v, fwd_v;
  logic         in_rdy, fwd_rdy, out_ena;
  logic [127:0] out_v;
  logic [15:0]  in_cnt, fwd_cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  indication_pipe_arb #(
    .DATA_WIDTH(128),
    .DEPTH(4),
    .FWD_WEIGHT(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .in_enq_ena_i(in_ena),
    .in_enq_v_i(in_v),
    .in_enq_rdy_o(in_rdy),
    .forward_enq_ena_i(fwd_ena),
    .forward_enq_v_i(fwd_v),
    .forward_enq_rdy_o(fwd_rdy),
    .out_enq_ena_o(out_ena),
    .out_enq_v_o(out_v),
    .out_enq_rdy_i(out_rdy),
    .stat_in_count_o(in_cnt),
    .stat_fwd_count_o(fwd_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_ena !== 1'b0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_out: got ena=%b data %0h expected no transfer", out_ena, out_v);
      end else begin
        check("out_data", out_v, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq_in(input logic [127:0] d);
    in_ena = 1'b1;
    in_v   = d;
    tick();
    in_ena = 1'b0;
  endtask

  task automatic enq_fwd(input logic [127:0] d);
    fwd_ena = 1'b1;
    fwd_v   = d;
    tick();
    fwd_ena = 1'b0;
  endtask

  task automatic wait_drain(input int n);
    for (int i = 0; i < n && exp_q.size() != 0; i++) tick();
    check("drained", 128'(exp_q.size()), 128'd0);
  endtask

  function automatic logic [127:0] fw(input int k);
    return 128'(32'hF000 + k);
  endfunction

  function automatic logic [127:0] iw(input int k);
    return 128'(32'hA000 + k);
  endfunction

  initial begin
    int k;
    logic ena_pat [4];
    ena_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; in_ena = 1'b0; fwd_ena = 1'b0; out_rdy = 1'b0; in_v = '0; fwd_v = '0;

    // Reset behaviour and first cycle after release
    tick();
    check("rst_in_rdy", 128'(in_rdy), 128'd0);
    check("rst_fwd_rdy", 128'(fwd_rdy), 128'd0);
    check("rst_out_ena", 128'(out_ena), 128'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_rdy", 128'(in_rdy), 128'd1);
    check("post_rst_fwd_rdy", 128'(fwd_rdy), 128'd1);
    check("post_rst_in_cnt", 128'(in_cnt), 128'd0);
    check("post_rst_fwd_cnt", 128'(fwd_cnt), 128'd0);

    // Single in message, visible the cycle after its write
    out_rdy = 1'b1;
    exp_q.push_back(128'h0000_0000_0000_0000_0000_0002_0000_0002);
    enq_in(128'h0000_0000_0000_0000_0000_0002_0000_0002);
    check("single_ena", 128'(out_ena), 128'd1);
    tick();
    check("single_in_cnt", 128'(in_cnt), 128'd1);
    check("single_empty", 128'(out_ena), 128'd0);

    // Weighted round robin: F1 F2 I1 F3 F4 I2 F5 F6 I3, F5/F6 refilled as space frees
    out_rdy = 1'b0;
    for (int j = 1; j <= 4; j++) enq_fwd(fw(j));
    for (int j = 1; j <= 3; j++) enq_in(iw(j));
    exp_q.push_back(fw(1)); exp_q.push_back(fw(2)); exp_q.push_back(iw(1));
    exp_q.push_back(fw(3)); exp_q.push_back(fw(4)); exp_q.push_back(iw(2));
    exp_q.push_back(fw(5)); exp_q.push_back(fw(6)); exp_q.push_back(iw(3));
    out_rdy = 1'b1;
    k = 5;
    for (int c = 0; c < 9; c++) begin
      if (k <= 6 && fwd_rdy) begin
        fwd_ena = 1'b1;
        fwd_v   = fw(k);
        k++;
      end else begin
        fwd_ena = 1'b0;
      end
      #1;
      check("wrr_ena", 128'(out_ena), 128'd1);
      tick();
    end
    fwd_ena = 1'b0;
    wait_drain(4);
    check("wrr_in_cnt", 128'(in_cnt), 128'd4);
    check("wrr_fwd_cnt", 128'(fwd_cnt), 128'd6);

    // Full forward FIFO: 5th enqueue is a violation and must be dropped
    out_rdy = 1'b0;
    for (int j = 0; j < 5; j++) begin
      fwd_ena = 1'b1;
      fwd_v   = fw(16 + j);
      if (j == 4) check("full_rdy_low", 128'(fwd_rdy), 128'd0);
      tick();
    end
    fwd_ena = 1'b0;
    for (int j = 0; j < 4; j++) exp_q.push_back(fw(16 + j));
    out_rdy = 1'b1;
    #1;
    check("full_deq_ena", 128'(out_ena), 128'd1);
    check("full_deq_rdy", 128'(fwd_rdy), 128'd0);
    tick();
    check("full_rdy_back", 128'(fwd_rdy), 128'd1);
    wait_drain(6);
    tick();
    check("full_fwd_cnt", 128'(fwd_cnt), 128'd10);

    // Stall pattern 1,0,0,1: last=FWD at burst limit, so I1 goes first, then F
    out_rdy = 1'b0;
    enq_in(iw(32)); enq_in(iw(33));
    enq_fwd(fw(32)); enq_fwd(fw(33));
    exp_q.push_back(iw(32)); exp_q.push_back(fw(32));
    exp_q.push_back(fw(33)); exp_q.push_back(iw(33));
    for (int c = 0; c < 4; c++) begin
      out_rdy = ena_pat[c];
      #1;
      check("stall_ena", 128'(out_ena), 128'(ena_pat[c]));
      tick();
    end
    out_rdy = 1'b1;
    wait_drain(6);
    tick();
    check("stall_in_cnt", 128'(in_cnt), 128'd6);
    check("stall_fwd_cnt", 128'(fwd_cnt), 128'd12);

    // Reset mid-drain discards buffered messages and counters
    out_rdy = 1'b0;
    enq_in(iw(48)); enq_in(iw(49));
    enq_fwd(fw(48));
    exp_q.push_back(fw(48));
    out_rdy = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_ena", 128'(out_ena), 128'd0);
    check("mid_rst_in_rdy", 128'(in_rdy), 128'd0);
    check("mid_rst_fwd_rdy", 128'(fwd_rdy), 128'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("after_rst_in_cnt", 128'(in_cnt), 128'd0);
    check("after_rst_fwd_cnt", 128'(fwd_cnt), 128'd0);
    check("after_rst_rdy", 128'({in_rdy, fwd_rdy}), 128'd3);
    check("after_rst_queue", 128'(exp_q.size()), 128'd0);
    for (int c = 0; c < 5; c++) tick();

    // 65537 in messages: counter wraps to 1
    k = 0;
    for (int c = 0; c < 70000 && k < 65537; c++) begin
      if (in_rdy) begin
        in_ena = 1'b1;
        in_v   = 128'(k);
        exp_q.push_back(128'(k));
        k++;
      end else begin
        in_ena = 1'b0;
      end
      tick();
    end
    in_ena = 1'b0;
    check("wrap_issued", 128'(k), 128'd65537);
    wait_drain(10);
    tick();
    check("wrap_in_cnt", 128'(in_cnt), 128'd1);
    check("wrap_fwd_cnt", 128'(fwd_cnt), 128'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
